// File: rtl/bus_cmd_master.sv
// Purpose : single-outstanding command master. It turns a host command handshake into
//           one bus request pulse and returns the slave's completion, or a timeout error,
//           as a held response.
// Latency : command accept to m_req is 1 cycle. m_req to rsp_valid is (ack offset + 1)
//           cycles, or TIMEOUT+1 cycles on timeout. The shortest command-to-command
//           period is 4 cycles.
// Backpr. : cmd_ready is low from command accept until the response is taken. The
//           response and its data stay held while rsp_ready is low.
// Ports   : cmd_*  host command channel (valid/ready; rd_wr_l 1=read).
//           rsp_*  host response channel (valid/ready; rd_data, err).
//           m_*    bus master side: m_req pulse with held direction, address and data;
//                  m_ack pulse with m_rd_data coming back from the slave.
module bus_cmd_master #(
  parameter int DATAW   = 32,
  parameter int ADDRW   = 24,
  parameter int TIMEOUT = 63   // legal 1..255
) (
  input  logic             bus_clk,
  input  logic             bus_reset_l,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rd_wr_l,
  input  logic [ADDRW-1:0] cmd_addr,
  input  logic [DATAW-1:0] cmd_wr_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DATAW-1:0] rsp_rd_data,
  output logic             rsp_err,
  output logic             m_req,
  output logic             m_rd_wr_l,
  output logic [ADDRW-1:0] m_addr,
  output logic [DATAW-1:0] m_wr_data,
  input  logic             m_ack,
  input  logic [DATAW-1:0] m_rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         cnt_inc;
  logic               timeout_hit;
  logic               m_rd_wr_l_q, m_rd_wr_l_d;
  logic [ADDRW-1:0]   m_addr_q, m_addr_d;
  logic [DATAW-1:0]   m_wr_data_q, m_wr_data_d;
  logic [DATAW-1:0]   rsp_rd_data_q, rsp_rd_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               cmd_hs;

  // Counter saturates at all-ones rather than wrapping.
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  // The incremented count is the number of WAIT cycles seen so far. Hitting TO_LIM
  // therefore lands the response exactly TIMEOUT+1 cycles after the m_req cycle.
  assign timeout_hit = (cnt_inc >= TO_LIM);
  assign cmd_hs      = cmd_valid && (state_q == ST_IDLE);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_valid)               state_d = ST_REQ;
      ST_REQ:                               state_d = ST_WAIT;
      ST_WAIT: if (m_ack || timeout_hit)    state_d = ST_RSP;
      ST_RSP:  if (rsp_ready)               state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // cmd_ready is gated by reset so that every output reads 0 while reset is held.
  always_comb begin
    cmd_ready = bus_reset_l && (state_q == ST_IDLE);
    m_req     = (state_q == ST_REQ);
    rsp_valid = (state_q == ST_RSP);
  end

  // ---------------- datapath next-state ----------------
  always_comb begin
    m_rd_wr_l_d   = m_rd_wr_l_q;
    m_addr_d      = m_addr_q;
    m_wr_data_d   = m_wr_data_q;
    cnt_d         = cnt_q;
    rsp_rd_data_d = rsp_rd_data_q;
    rsp_err_d     = rsp_err_q;

    if (cmd_hs) begin
      m_rd_wr_l_d = cmd_rd_wr_l;
      m_addr_d    = cmd_addr;
      m_wr_data_d = cmd_wr_data;
    end

    if (state_q == ST_REQ) begin
      cnt_d = 8'd0;
    end

    if (state_q == ST_WAIT) begin
      cnt_d = cnt_inc;
      // An ack takes priority over a timeout in the same cycle.
      if (m_ack) begin
        rsp_rd_data_d = m_rd_wr_l_q ? m_rd_data : '0;
        rsp_err_d     = 1'b0;
      end else if (timeout_hit) begin
        rsp_rd_data_d = '0;
        rsp_err_d     = 1'b1;
      end
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      m_rd_wr_l_q   <= 1'b0;
      m_addr_q      <= '0;
      m_wr_data_q   <= '0;
      cnt_q         <= 8'd0;
      rsp_rd_data_q <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      m_rd_wr_l_q   <= m_rd_wr_l_d;
      m_addr_q      <= m_addr_d;
      m_wr_data_q   <= m_wr_data_d;
      cnt_q         <= cnt_d;
      rsp_rd_data_q <= rsp_rd_data_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign m_rd_wr_l   = m_rd_wr_l_q;
  assign m_addr      = m_addr_q;
  assign m_wr_data   = m_wr_data_q;
  assign rsp_rd_data = rsp_rd_data_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_bus_cmd_master.sv
// Bench for bus_cmd_master: a cycle-timeline reference model checks every output each
// cycle, and directed transactions pin latencies and data with hand-computed literals.
module tb_bus_cmd_master;
  localparam int DATAW   = 32;
  localparam int ADDRW   = 24;
  localparam int TIMEOUT = 63;

  logic             bus_clk = 1'b0;
  logic             bus_reset_l = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_rd_wr_l = 1'b0;
  logic [ADDRW-1:0] cmd_addr = '0;
  logic [DATAW-1:0] cmd_wr_data = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [DATAW-1:0] rsp_rd_data;
  logic             rsp_err;
  logic             m_req;
  logic             m_rd_wr_l;
  logic [ADDRW-1:0] m_addr;
  logic [DATAW-1:0] m_wr_data;
  logic             m_ack = 1'b0;
  logic [DATAW-1:0] m_rd_data = '0;

  bus_cmd_master #(.DATAW(DATAW), .ADDRW(ADDRW), .TIMEOUT(TIMEOUT)) dut (
    .bus_clk(bus_clk), .bus_reset_l(bus_reset_l),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr_l(cmd_rd_wr_l),
    .cmd_addr(cmd_addr), .cmd_wr_data(cmd_wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd_data(rsp_rd_data),
    .rsp_err(rsp_err),
    .m_req(m_req), .m_rd_wr_l(m_rd_wr_l), .m_addr(m_addr), .m_wr_data(m_wr_data),
    .m_ack(m_ack), .m_rd_data(m_rd_data)
  );

  always #5 bus_clk = ~bus_clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Timeline view: a command accepted in cycle c puts its request in cycle c+1. The
  // response starts the cycle after the first ack in (req, req+TIMEOUT], or at
  // req+TIMEOUT+1 when no ack arrives. It stays up until the host takes it.
  int               cyc = 0;
  bit               md_busy = 0;
  int               md_req_cyc = -1;
  int               md_rsp_cyc = -1;
  logic             md_rw = 1'b0;
  logic [ADDRW-1:0] md_addr = '0;
  logic [DATAW-1:0] md_wd = '0;
  logic [DATAW-1:0] md_data = '0;
  logic             md_err = 1'b0;
  int               req_pulses = 0;

  always @(negedge bus_clk) begin
    bit exp_req, exp_rv;
    if (!bus_reset_l) begin
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_m_req", m_req, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_wr_data", m_wr_data, 0);
      chk("rst_m_rd_wr_l", m_rd_wr_l, 0);
      chk("rst_rsp_rd_data", rsp_rd_data, 0);
      chk("rst_rsp_err", rsp_err, 0);
      md_busy = 0; md_req_cyc = -1; md_rsp_cyc = -1;
      md_rw = 1'b0; md_addr = '0; md_wd = '0; md_data = '0; md_err = 1'b0;
    end else begin
      exp_req = md_busy && (cyc == md_req_cyc);
      exp_rv  = md_busy && (md_rsp_cyc >= 0) && (cyc >= md_rsp_cyc);
      chk("mdl_cmd_ready", cmd_ready, !md_busy);
      chk("mdl_m_req", m_req, exp_req);
      chk("mdl_rsp_valid", rsp_valid, exp_rv);
      chk("mdl_m_rd_wr_l", m_rd_wr_l, md_rw);
      chk("mdl_m_addr", m_addr, md_addr);
      chk("mdl_m_wr_data", m_wr_data, md_wd);
      if (exp_rv) begin
        chk("mdl_rsp_rd_data", rsp_rd_data, md_data);
        chk("mdl_rsp_err", rsp_err, md_err);
      end
      if (m_req) req_pulses++;
      // advance the model using the inputs the coming edge will sample
      if (!md_busy) begin
        if (cmd_valid) begin
          md_busy = 1; md_req_cyc = cyc + 1; md_rsp_cyc = -1;
          md_rw = cmd_rd_wr_l; md_addr = cmd_addr; md_wd = cmd_wr_data;
        end
      end else if (md_rsp_cyc < 0) begin
        if (cyc > md_req_cyc) begin
          if (m_ack) begin
            md_rsp_cyc = cyc + 1; md_data = md_rw ? m_rd_data : '0; md_err = 1'b0;
          end else if (cyc - md_req_cyc == TIMEOUT) begin
            md_rsp_cyc = cyc + 1; md_data = '0; md_err = 1'b1;
          end
        end
      end else if (exp_rv && rsp_ready) begin
        md_busy = 0;
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  // Presents a command and returns in the m_req cycle.
  task automatic start_cmd(input logic rw, input logic [ADDRW-1:0] addr,
                           input logic [DATAW-1:0] wd);
    int n;
    cmd_rd_wr_l = rw; cmd_addr = addr; cmd_wr_data = wd; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    if (!cmd_ready) chk("cmd_ready_wait_expired", 0, 1);
    tick();
    cmd_valid = 1'b0;
    chk("lit_m_req_pulse", m_req, 1);
    chk("lit_m_addr", m_addr, addr);
  endtask

  // Plays the slave side and returns in the first rsp_valid cycle. Cycle offsets are
  // counted from the m_req cycle (offset 0). ack_dly < 0 means no ack at all.
  task automatic wait_rsp(input logic req_ack, input int ack_dly,
                          input logic [DATAW-1:0] rd, input int exp_lat,
                          input logic [DATAW-1:0] exp_data, input logic exp_err);
    int lat;
    lat = -1;
    m_rd_data = rd;
    m_ack = req_ack;
    for (int n = 1; n <= 300; n++) begin
      tick();
      m_ack = (n == ack_dly);
      if (rsp_valid) begin lat = n; break; end
    end
    m_ack = 1'b0;
    chk("lit_rsp_latency", 64'(lat), 64'(exp_lat));
    chk("lit_rsp_rd_data", rsp_rd_data, exp_data);
    chk("lit_rsp_err", rsp_err, exp_err);
  endtask

  task automatic take_rsp(input int hold);
    repeat (hold) tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("lit_idle_cmd_ready", cmd_ready, 1);
    chk("lit_idle_rsp_valid", rsp_valid, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p0;
    repeat (3) tick();
    chk("lit_reset_cmd_ready", cmd_ready, 0);
    chk("lit_reset_m_req", m_req, 0);
    bus_reset_l = 1'b1;
    #1;
    chk("lit_post_reset_cmd_ready", cmd_ready, 1);
    tick();

    // write, ack 3 cycles after m_req: exactly one request pulse, zero data
    p0 = req_pulses;
    start_cmd(1'b0, 24'h000100, 32'hA5A5_0001);
    chk("lit_wr_m_wr_data", m_wr_data, 32'hA5A5_0001);
    chk("lit_wr_m_rd_wr_l", m_rd_wr_l, 0);
    wait_rsp(1'b0, 3, 32'h9999_9999, 4, 32'h0, 1'b0);
    take_rsp(0);
    chk("lit_wr_one_pulse", 64'(req_pulses - p0), 64'd1);

    // read, ack 1 cycle after m_req
    start_cmd(1'b1, 24'h000204, 32'h0);
    wait_rsp(1'b0, 1, 32'h1234_5678, 2, 32'h1234_5678, 1'b0);
    take_rsp(0);

    // read with no ack: timeout, then stray acks in RSP and IDLE are ignored
    start_cmd(1'b1, 24'h000300, 32'h0);
    wait_rsp(1'b0, -1, 32'h7777_7777, 64, 32'h0, 1'b1);
    repeat (9) tick();
    m_ack = 1'b1; m_rd_data = 32'h5555_5555;
    tick();
    m_ack = 1'b0;
    chk("lit_late_ack_rsp_err", rsp_err, 1);
    chk("lit_late_ack_rsp_data", rsp_rd_data, 0);
    take_rsp(0);
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    tick();
    chk("lit_idle_ack_cmd_ready", cmd_ready, 1);
    start_cmd(1'b0, 24'h000310, 32'h0000_0310);
    wait_rsp(1'b0, 2, 32'h0, 3, 32'h0, 1'b0);
    take_rsp(0);

    // ack in the same cycle the timeout would fire
    start_cmd(1'b1, 24'h000400, 32'h0);
    wait_rsp(1'b0, 63, 32'hCAFE_F00D, 64, 32'hCAFE_F00D, 1'b0);
    take_rsp(0);

    // ack during the m_req cycle is ignored; the later one completes
    start_cmd(1'b1, 24'h000500, 32'h0);
    wait_rsp(1'b1, 5, 32'h0000_55AA, 6, 32'h0000_55AA, 1'b0);
    take_rsp(0);

    // write returns zero even with nonzero bus read data
    start_cmd(1'b0, 24'h000504, 32'h0102_0304);
    wait_rsp(1'b0, 2, 32'hFFFF_FFFF, 3, 32'h0, 1'b0);
    take_rsp(0);

    // response held for 20 cycles with a new command waiting
    start_cmd(1'b1, 24'h000600, 32'h0);
    wait_rsp(1'b0, 2, 32'h1111_2222, 3, 32'h1111_2222, 1'b0);
    cmd_rd_wr_l = 1'b0; cmd_addr = 24'h000700; cmd_wr_data = 32'hDEAD_0007;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("lit_hold_cmd_ready", cmd_ready, 0);
      chk("lit_hold_m_req", m_req, 0);
      chk("lit_hold_rsp_data", rsp_rd_data, 32'h1111_2222);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("lit_after_hold_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("lit_after_hold_m_req", m_req, 1);
    chk("lit_after_hold_m_addr", m_addr, 24'h000700);
    wait_rsp(1'b0, 1, 32'h0, 2, 32'h0, 1'b0);
    take_rsp(0);

    // back-to-back commands: next m_req exactly 4 cycles after the previous one
    start_cmd(1'b0, 24'h000800, 32'h0000_0008);
    wait_rsp(1'b0, 1, 32'h0, 2, 32'h0, 1'b0);
    rsp_ready = 1'b1;
    cmd_rd_wr_l = 1'b1; cmd_addr = 24'h000900; cmd_wr_data = 32'h0; cmd_valid = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("lit_b2b_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("lit_b2b_m_req", m_req, 1);
    chk("lit_b2b_m_addr", m_addr, 24'h000900);
    wait_rsp(1'b0, 1, 32'h0000_0900, 2, 32'h0000_0900, 1'b0);
    take_rsp(0);

    // reset during WAIT aborts; a fresh read then completes
    start_cmd(1'b1, 24'h000A00, 32'hFEED_FACE);
    repeat (3) tick();
    bus_reset_l = 1'b0;
    #1;
    chk("lit_abort_m_req", m_req, 0);
    chk("lit_abort_rsp_valid", rsp_valid, 0);
    chk("lit_abort_cmd_ready", cmd_ready, 0);
    chk("lit_abort_m_addr", m_addr, 0);
    chk("lit_abort_m_wr_data", m_wr_data, 0);
    chk("lit_abort_m_rd_wr_l", m_rd_wr_l, 0);
    tick();
    tick();
    bus_reset_l = 1'b1;
    tick();
    chk("lit_rearm_cmd_ready", cmd_ready, 1);
    start_cmd(1'b1, 24'h000B00, 32'h0);
    wait_rsp(1'b0, 2, 32'h0BAD_BEEF, 3, 32'h0BAD_BEEF, 1'b0);
    take_rsp(0);

    tick();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
